// File: rtl/strobe_gen_pkg.sv
// Shared definitions for the strobe generator: channel mode encodings and
// the per-cycle action each channel takes.
package strobe_gen_pkg;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  typedef enum logic [1:0] {
    CH_SYNC,
    CH_IDLE,
    CH_TERM,
    CH_COUNT
  } chan_action_e;

  // Sync outranks everything, a disabled channel parks, otherwise count or wrap.
  function automatic chan_action_e next_action(input logic sync, input logic en,
                                               input logic term);
    if (sync)      return CH_SYNC;
    else if (!en)  return CH_IDLE;
    else if (term) return CH_TERM;
    else           return CH_COUNT;
  endfunction

endpackage

// File: rtl/strobe_chan.sv
// One strobe channel: counter, active/shadow interval pair and output register.
// A shadow interval is promoted to active only when the counter restarts.
module strobe_chan
  import strobe_gen_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] RESET_INTERVAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] interval,
  input  logic             load,
  input  logic             sync,
  output logic             clk_out,
  output logic             pending
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] shd;
  chan_action_e     action;
  logic             apply;

  always_comb begin
    action = next_action(sync, en, cnt == act);
    apply  = pending && (action != CH_COUNT);
  end

  // A load on the same edge as an apply keeps pending set; act sees the old shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      act     <= RESET_INTERVAL;
      shd     <= '0;
      pending <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      if (load)
        shd <= interval;

      if (load)
        pending <= 1'b1;
      else if (apply)
        pending <= 1'b0;

      if (apply)
        act <= shd;

      case (action)
        CH_SYNC, CH_IDLE: begin
          cnt     <= '0;
          clk_out <= 1'b0;
        end
        CH_TERM: begin
          cnt     <= '0;
          clk_out <= (mode == MODE_SQUARE) ? ~clk_out : 1'b1;
        end
        CH_COUNT: begin
          cnt <= cnt + WIDTH'(1);
          if (mode == MODE_PULSE)
            clk_out <= 1'b0;
        end
        default: begin
          cnt     <= '0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/strobe_gen.sv
// Multi-channel programmable strobe / square-wave generator; each channel is an
// independent strobe_chan, with sync restarting every channel's phase together.
module strobe_gen
  import strobe_gen_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               CHANNELS       = 4,
  parameter logic [WIDTH-1:0] RESET_INTERVAL = {WIDTH{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] interval,
  input  logic [CHANNELS-1:0]       load,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       pending
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    strobe_chan #(
      .WIDTH          (WIDTH),
      .RESET_INTERVAL (RESET_INTERVAL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .mode     (mode[i]),
      .interval (interval[i*WIDTH +: WIDTH]),
      .load     (load[i]),
      .sync     (sync),
      .clk_out  (clk_out[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_strobe_gen.sv
// Directed bench for strobe_gen: reset, pulse/square periods, shadow loading,
// load/terminal collision, sync alignment, async reset and zero-interval cases.
module tb_strobe_gen;

  localparam int         WIDTH    = 8;
  localparam int         CHANNELS = 4;
  localparam logic [7:0] RST_INT  = 8'd5;

  logic                      clk;
  logic                      rst;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*WIDTH-1:0] interval;
  logic [CHANNELS-1:0]       load;
  logic                      sync;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       pending;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_v;

  strobe_gen #(
    .WIDTH          (WIDTH),
    .CHANNELS       (CHANNELS),
    .RESET_INTERVAL (RST_INT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .interval (interval),
    .load     (load),
    .sync     (sync),
    .clk_out  (clk_out),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic set_interval(input int ch, input logic [7:0] v);
    interval[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; mode = '0; interval = '0; load = '0; sync = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("reset_clk_out", 32'(clk_out), 32'h0);
    check_output("reset_pending", 32'(pending), 32'h0);

    // Inputs must be ignored while reset is held
    load = '1; en = '1;
    apply_stimulus();
    check_output("load_ignored_in_reset", 32'(pending), 32'h0);
    check_output("en_ignored_in_reset", 32'(clk_out), 32'h0);
    load = '0; en = '0; rst = 1'b0;

    $display("[TB] reset interval on ch3");
    en = 4'b1000;
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus();
      check_output($sformatf("rst_interval_k%0d", k), 32'(clk_out),
                   (k % 6 == 0) ? 32'h8 : 32'h0);
    end
    en = '0;

    $display("[TB] ch0 pulse interval 3");
    set_interval(0, 8'd3); load = 4'b0001;
    apply_stimulus();
    check_output("pend_after_load", 32'(pending), 32'h1);
    load = '0;
    apply_stimulus();
    check_output("pend_applied_disabled", 32'(pending), 32'h0);
    en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus();
      check_output($sformatf("pulse3_k%0d", k), 32'(clk_out),
                   (k % 4 == 0) ? 32'h1 : 32'h0);
    end

    $display("[TB] ch1 square interval 2");
    en = '0; set_interval(1, 8'd2); load = 4'b0010;
    apply_stimulus();
    load = '0;
    apply_stimulus();
    en = 4'b0010; mode = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus();
      check_output($sformatf("square2_k%0d", k), 32'(clk_out),
                   (((k / 3) % 2) == 1) ? 32'h2 : 32'h0);
    end

    $display("[TB] ch0 reload mid-period");
    en = '0; mode = '0; set_interval(0, 8'd7); load = 4'b0001;
    apply_stimulus();
    load = '0;
    apply_stimulus();
    en = 4'b0001;
    apply_stimulus();
    check_output("i7_k1", 32'(clk_out), 32'h0);
    apply_stimulus();
    check_output("i7_k2", 32'(clk_out), 32'h0);
    set_interval(0, 8'd1); load = 4'b0001;
    apply_stimulus();
    load = '0;
    check_output("pend_set_midperiod", 32'(pending), 32'h1);
    for (int k = 4; k <= 7; k++) begin
      apply_stimulus();
      check_output($sformatf("i7_clk_k%0d", k), 32'(clk_out), 32'h0);
      check_output($sformatf("i7_pend_k%0d", k), 32'(pending), 32'h1);
    end
    apply_stimulus();
    check_output("i7_terminal_clk", 32'(clk_out), 32'h1);
    check_output("i7_terminal_pend", 32'(pending), 32'h0);

    $display("[TB] load colliding with terminal");
    set_interval(0, 8'd4); load = 4'b0001;
    apply_stimulus();
    check_output("i1_k1_clk", 32'(clk_out), 32'h0);
    check_output("i1_k1_pend", 32'(pending), 32'h1);
    set_interval(0, 8'd2); load = 4'b0001;
    apply_stimulus();
    load = '0;
    check_output("collide_clk", 32'(clk_out), 32'h1);
    check_output("collide_pend", 32'(pending), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus();
      check_output($sformatf("collide_clk_k%0d", k), 32'(clk_out),
                   (k == 5 || k == 8) ? 32'h1 : 32'h0);
      check_output($sformatf("collide_pend_k%0d", k), 32'(pending),
                   (k < 5) ? 32'h1 : 32'h0);
    end

    $display("[TB] sync across four channels");
    en = '0; mode = '0;
    set_interval(0, 8'd3); set_interval(1, 8'd2);
    set_interval(2, 8'd4); set_interval(3, 8'd1);
    load = 4'b1111;
    apply_stimulus();
    load = '0;
    apply_stimulus();
    check_output("multi_pend_applied", 32'(pending), 32'h0);
    en = 4'b1111;
    apply_stimulus();
    apply_stimulus();
    set_interval(3, 8'd3); load = 4'b1000;
    apply_stimulus();
    load = '0;
    check_output("pre_sync_clk_out", 32'(clk_out), 32'h2);
    check_output("pre_sync_pend", 32'(pending), 32'h8);
    sync = 1'b1;
    apply_stimulus();
    sync = 1'b0;
    check_output("sync_clk_out", 32'(clk_out), 32'h0);
    check_output("sync_pend", 32'(pending), 32'h0);
    for (int k = 1; k <= 11; k++) begin
      exp_v[0] = (k % 4 == 0);
      exp_v[1] = (k % 3 == 0);
      exp_v[2] = (k % 5 == 0);
      exp_v[3] = (k % 4 == 0);
      apply_stimulus();
      check_output($sformatf("aligned_k%0d", k), 32'(clk_out), 32'(exp_v));
    end
    set_interval(0, 8'd6); load = 4'b0001;
    apply_stimulus();
    load = '0;
    check_output("aligned_k12", 32'(clk_out), 32'hB);
    check_output("pend_before_rst", 32'(pending), 32'h1);

    $display("[TB] asynchronous reset mid-period");
    #2 rst = 1'b1;
    #1;
    check_output("async_rst_clk_out", 32'(clk_out), 32'h0);
    check_output("async_rst_pend", 32'(pending), 32'h0);
    en = 4'b0001; mode = '0;
    #1 rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus();
      check_output($sformatf("post_rst_k%0d", k), 32'(clk_out),
                   (k % 6 == 0) ? 32'h1 : 32'h0);
    end

    $display("[TB] zero interval on ch2");
    en = '0; set_interval(2, 8'd0); load = 4'b0100;
    apply_stimulus();
    load = '0;
    apply_stimulus();
    en = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus();
      check_output($sformatf("zero_pulse_k%0d", k), 32'(clk_out), 32'h4);
    end
    mode = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus();
      check_output($sformatf("zero_square_k%0d", k), 32'(clk_out),
                   (k % 2 == 1) ? 32'h0 : 32'h4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/strobe_gen.md
STROBE_GEN -- requirements
Module: strobe_gen

Interface
REQ-001 Parameter WIDTH, default 16, counter and interval width in bits (range 2..32).
REQ-002 Parameter CHANNELS, default 4, number of independent strobe channels (range 1..16).
REQ-003 Parameter RESET_INTERVAL, default {WIDTH{1'b1}}, active interval of every channel after reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 en  input  CHANNELS  per-channel enable; bit i controls channel i.
REQ-007 mode  input  CHANNELS  per-channel mode; 0 = pulse, 1 = square.
REQ-008 interval  input  CHANNELS*WIDTH  new interval values; channel i at [i*WIDTH +: WIDTH].
REQ-009 load  input  CHANNELS  per-channel single-cycle request to capture interval slice i.
REQ-010 sync  input  1  global phase restart of all channels.
REQ-011 clk_out  output  CHANNELS  registered strobe or square output per channel.
REQ-012 pending  output  CHANNELS  high while a loaded interval awaits application.

Function
REQ-013 Each channel SHALL hold a WIDTH-bit counter cnt, an active interval act, a shadow interval shd, a pending flag and an output register.
REQ-014 load[i] high SHALL write shd <= interval slice i and set pending[i] on the same edge; back-to-back loads overwrite shd, last one wins.
REQ-015 Terminal condition SHALL be en[i] high and cnt == act.
REQ-016 At terminal: cnt <= 0; pulse mode clk_out[i] <= 1; square mode clk_out[i] <= ~clk_out[i]; if pending, act <= shd.
REQ-017 Otherwise with en[i] high: cnt <= cnt + 1; pulse mode clk_out[i] <= 0; square mode clk_out[i] holds.
REQ-018 Pulse period SHALL be act+1 clocks with one-cycle high; square period SHALL be 2*(act+1) clocks, 50% duty.
REQ-019 act == 0: pulse mode clk_out[i] constantly 1; square mode toggles every cycle.
REQ-020 en[i] low: cnt <= 0, clk_out[i] <= 0, and if pending, act <= shd (disabled channel applies immediately).
REQ-021 sync high: every channel cnt <= 0, clk_out <= 0, pending applied; sync has priority over terminal.
REQ-022 pending clear on apply SHALL lose to load on the same edge: shd takes the new value, pending stays set, act takes the old shd.
REQ-023 Mode change mid-period SHALL take effect on the next edge without resetting cnt; clk_out may carry stale level until the next terminal.
REQ-024 Counter SHALL never exceed act; no wrap-around beyond act is legal.

Reset
REQ-025 rst high SHALL asynchronously force cnt = 0, clk_out = 0, pending = 0, shd = 0, act = RESET_INTERVAL for every channel.
REQ-026 Inputs SHALL be ignored while rst is high; first counting edge is the first rising clk edge after rst deasserts.

Structure
REQ-027 Shared package strobe_gen_pkg SHALL hold MODE_PULSE = 1'b0 and MODE_SQUARE = 1'b1.
REQ-028 One sub-module strobe_chan SHALL implement a single channel, instantiated CHANNELS times by generate loop; sync fans out to all instances.

Verification
REQ-029 Reset release, load ch0 interval=3, en[0]=1, mode=pulse -> clk_out[0] high 1 cycle in every 4, first high after the 4th enabled edge.
REQ-030 ch1 square, interval=2 -> clk_out[1] 3 high, 3 low, repeating; duty exactly 50%.
REQ-031 ch0 running interval=7, load interval=1 at cnt=2 -> pending high until terminal at cnt=7, then period becomes 2; pending low after.
REQ-032 Load and terminal on same edge -> act takes old shd, pending remains 1, new value applied at next terminal.
REQ-033 sync asserted mid-period on 4 channels with mixed intervals -> all cnt 0, all clk_out 0 next cycle, subsequent strobes phase-aligned.
REQ-034 rst asserted asynchronously mid-period with pending set -> outputs 0 immediately, pending 0, act = RESET_INTERVAL.
